// File: rtl/cbus_arb_pkg.sv
// rtl/cbus_arb_pkg.sv - cbus request/response types and arbiter FSM state
package cbus_arb_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  localparam int BEAT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// rtl/cbus_arb_pick.sv - combinational winner select: lowest valid index at or
// above start, wrapping to the lowest valid index overall
module cbus_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
    // A candidate at or above start overrides the wrapped choice.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i] && (IDX_W'(i) >= start)) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - burst-granting cbus arbiter; CBUS_ARB_RR_EN selects
// round-robin, otherwise fixed lowest-index priority
module cbus_arbiter
  import cbus_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        creqs  [NUM_REQ],
  output cbus_resp_t       cresps [NUM_REQ],
  output cbus_req_t        creq,
  input  cbus_resp_t       cresp,
  output logic             busy,
  output logic [IDX_W-1:0] owner,
  output logic             proto_err
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  start;

  logic [NUM_REQ-1:0] valid_vec;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [BEAT_W-1:0]  beat_inc;
  logic [BEAT_W-1:0]  beats_exp;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_valid
    assign valid_vec[g] = creqs[g].valid;
  end

  cbus_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid (valid_vec),
    .start (start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_any) begin
      ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign beat_inc  = beat_q + BEAT_W'(1);
  assign beats_exp = BEAT_W'(creqs[owner_q].len) + BEAT_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    err_d   = err_q;
    creq    = '0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy = 1'b1;
        creq = creqs[owner_q];
        if (cresp.ready) begin
          beat_d = beat_inc;
          // Early last and a missing last both count as a length violation.
          if (cresp.last && beat_inc != beats_exp)  err_d = 1'b1;
          if (!cresp.last && beat_inc == beats_exp) err_d = 1'b1;
          if (cresp.last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      cresps[j] = (state_q == GRANT && owner_q == IDX_W'(j)) ? cresp : '0;
    end
  end

  assign owner     = owner_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - directed self-checking bench for cbus_arbiter
module tb_cbus_arbiter;
  import cbus_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creqs  [2];
  cbus_resp_t cresps [2];
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       busy;
  logic [0:0] owner;
  logic       proto_err;

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_owner [4];

  cbus_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .creqs     (creqs),
    .cresps    (cresps),
    .creq      (creq),
    .cresp     (cresp),
    .busy      (busy),
    .owner     (owner),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [3:0] l);
    creqs[i].valid = v;
    creqs[i].addr  = a;
    creqs[i].len   = l;
  endtask

  task automatic beat(input logic last, input logic [31:0] d);
    cresp.ready = 1'b1;
    cresp.last  = last;
    cresp.data  = d;
  endtask

  initial begin
`ifdef CBUS_ARB_RR_EN
    exp_owner[0] = 1'b0; exp_owner[1] = 1'b1; exp_owner[2] = 1'b0; exp_owner[3] = 1'b1;
`else
    exp_owner[0] = 1'b0; exp_owner[1] = 1'b0; exp_owner[2] = 1'b0; exp_owner[3] = 1'b0;
`endif
    reset    = 1'b1;
    creqs[0] = '0;
    creqs[1] = '0;
    cresp    = '0;
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_owner", 64'(owner), 0);
    chk("rst_err", 64'(proto_err), 0);
    chk("rst_creq_zero", 64'(creq === '0), 1);
    chk("rst_cresp0", 64'(cresps[0]), 0);
    chk("rst_cresp1", 64'(cresps[1]), 0);
    tick();
    reset = 1'b0;

    // Memory ready while idle must not leak to any master.
    beat(1'b1, 32'hdead_beef);
    #1;
    chk("idle_ready_c0", 64'(cresps[0]), 0);
    chk("idle_ready_c1", 64'(cresps[1]), 0);
    tick();
    cresp = '0;
    chk("idle_ready_busy", 64'(busy), 0);

    // Single master 1, MLEN2.
    set_req(1, 1'b1, 32'h1fc0_0000, MLEN2);
    #1;
    chk("t2_valid_t0", 64'(creq.valid), 0);
    tick();
    chk("t2_busy", 64'(busy), 1);
    chk("t2_owner", 64'(owner), 1);
    chk("t2_valid_t1", 64'(creq.valid), 1);
    chk("t2_addr", 64'(creq.addr), 64'h1fc0_0000);
    beat(1'b0, 32'h0000_00a1);
    #1;
    chk("t2_b1_ready", 64'(cresps[1].ready), 1);
    chk("t2_b1_data", 64'(cresps[1].data), 64'ha1);
    chk("t2_b1_c0", 64'(cresps[0]), 0);
    tick();
    beat(1'b1, 32'h0000_00a2);
    #1;
    chk("t2_b2_data", 64'(cresps[1].data), 64'ha2);
    chk("t2_b2_last", 64'(cresps[1].last), 1);
    chk("t2_b2_busy", 64'(busy), 1);
    tick();
    set_req(1, 1'b0, 32'h0, MLEN1);
    cresp = '0;
    chk("t2_busy_fall", 64'(busy), 0);
    chk("t2_valid_fall", 64'(creq.valid), 0);
    chk("t2_err", 64'(proto_err), 0);

    // Contention under the configured policy plus response isolation.
    set_req(0, 1'b1, 32'h0000_0100, MLEN2);
    set_req(1, 1'b1, 32'h0000_0200, MLEN1);
    tick();
    chk("t3_owner0", 64'(owner), 0);
    chk("t3_addr0", 64'(creq.addr), 64'h100);
    beat(1'b0, 32'h0000_00b1);
    #1;
    chk("t6_iso_b1", 64'(cresps[1]), 0);
    chk("t6_own_b1", 64'(cresps[0].data), 64'hb1);
    tick();
    beat(1'b1, 32'h0000_00b2);
    #1;
    chk("t6_iso_b2", 64'(cresps[1]), 0);
    tick();
    set_req(0, 1'b0, 32'h0, MLEN1);
    cresp = '0;
    chk("t3_dead_busy", 64'(busy), 0);
    chk("t3_dead_iso", 64'(cresps[1]), 0);
    tick();
    chk("t3_owner1", 64'(owner), 1);
    chk("t3_addr1", 64'(creq.addr), 64'h200);
    beat(1'b1, 32'h0000_00c1);
    tick();
    set_req(1, 1'b0, 32'h0, MLEN1);
    cresp = '0;
    chk("t3_err", 64'(proto_err), 0);

    // Both masters continuously valid for four single-beat bursts.
    set_req(0, 1'b1, 32'h0000_0300, MLEN1);
    set_req(1, 1'b1, 32'h0000_0400, MLEN1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t4_owner_%0d", k), 64'(owner), 64'(exp_owner[k]));
      beat(1'b1, 32'(k));
      tick();
      cresp = '0;
      chk($sformatf("t4_idle_%0d", k), 64'(busy), 0);
    end
    set_req(0, 1'b0, 32'h0, MLEN1);
    set_req(1, 1'b0, 32'h0, MLEN1);
    tick();
    chk("t4_err", 64'(proto_err), 0);

    // MLEN4 burst ended by last on beat 2; owner drops valid mid-burst.
    set_req(0, 1'b1, 32'h0000_0500, MLEN4);
    tick();
    chk("t5_busy", 64'(busy), 1);
    beat(1'b0, 32'h0000_00d1);
    tick();
    set_req(0, 1'b0, 32'h0000_0500, MLEN4);
    #1;
    chk("t5_drop_valid", 64'(creq.valid), 0);
    chk("t5_drop_busy", 64'(busy), 1);
    set_req(0, 1'b1, 32'h0000_0500, MLEN4);
    beat(1'b1, 32'h0000_00d2);
    #1;
    chk("t5_err_pre", 64'(proto_err), 0);
    tick();
    set_req(0, 1'b0, 32'h0, MLEN1);
    cresp = '0;
    chk("t5_err_set", 64'(proto_err), 1);
    chk("t5_idle", 64'(busy), 0);
    tick();
    tick();
    chk("t5_err_sticky", 64'(proto_err), 1);

    // Asynchronous reset during beat 2 of an MLEN4 burst.
    set_req(0, 1'b1, 32'h0000_0600, MLEN4);
    tick();
    beat(1'b0, 32'h0000_00e1);
    tick();
    beat(1'b0, 32'h0000_00e2);
    #1;
    chk("t1_pre_busy", 64'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t1_valid", 64'(creq.valid), 0);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_err", 64'(proto_err), 0);
    chk("t1_c0", 64'(cresps[0]), 0);
    set_req(0, 1'b0, 32'h0, MLEN1);
    cresp = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("t1_after_busy", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
